// File: rtl/wb_stage.sv
// Writeback stage: arbitrates the register-file write port between the in-order
// pipeline and an out-of-order multiply/divide unit through a one-entry buffer.
module wb_stage (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] in_O,
    input  logic [31:0] in_D,
    input  logic [31:0] in_ir,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic [4:0]  md_rd,
    input  logic        md_exception,
    input  logic        md_is_div,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        wb_stall,
    output logic        md_pending,
    output logic        md_overrun
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_STAT = 5'd30;
    localparam logic [1:0] CNT_MAX  = 2'd3;

    logic [4:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [4:0]  aluop_s;
    logic        unused_ir_s;

    logic        pipe_we_s;
    logic [4:0]  pipe_dest_s;
    logic [31:0] pipe_data_s;
    logic        pipe_wr_s;

    logic [4:0]  md_dest_s;
    logic [31:0] md_data_s;
    logic        md_wr_s;

    logic        buf_valid_r;
    logic [4:0]  buf_dest_r;
    logic [31:0] buf_data_r;
    logic [1:0]  wait_cnt_r;
    logic        overrun_r;

    logic        drain_s;
    logic        starve_s;
    logic        we_s;
    logic [4:0]  wreg_s;
    logic [31:0] wdata_s;
    logic        stall_s;

    assign opcode_s    = in_ir[31:27];
    assign rd_s        = in_ir[26:22];
    assign aluop_s     = in_ir[6:2];
    assign unused_ir_s = ^{in_ir[21:7], in_ir[1:0]};

    // Decode which register (if any) the instruction in the writeback latch writes.
    always_comb begin
        pipe_we_s   = 1'b0;
        pipe_dest_s = REG_ZERO;
        pipe_data_s = 32'd0;
        case (opcode_s)
            OP_RTYPE: begin
                if ((aluop_s != ALU_MUL) && (aluop_s != ALU_DIV)) begin
                    pipe_we_s   = 1'b1;
                    pipe_dest_s = rd_s;
                    pipe_data_s = in_O;
                end else begin
                    pipe_we_s   = 1'b0;
                end
            end
            OP_ADDI: begin
                pipe_we_s   = 1'b1;
                pipe_dest_s = rd_s;
                pipe_data_s = in_O;
            end
            OP_LW: begin
                pipe_we_s   = 1'b1;
                pipe_dest_s = rd_s;
                pipe_data_s = in_D;
            end
            OP_JAL: begin
                pipe_we_s   = 1'b1;
                pipe_dest_s = REG_RA;
                pipe_data_s = in_O;
            end
            OP_SETX: begin
                pipe_we_s   = 1'b1;
                pipe_dest_s = REG_STAT;
                pipe_data_s = in_O;
            end
            default: begin
                pipe_we_s   = 1'b0;
            end
        endcase
    end

    // A write aimed at r0 is treated as no write at all, so it never competes for the port.
    assign pipe_wr_s = pipe_we_s && (pipe_dest_s != REG_ZERO);

    // Map an arriving multdiv result to its destination; exceptions report through r30.
    always_comb begin
        md_dest_s = md_rd;
        md_data_s = md_result;
        if (md_exception) begin
            md_dest_s = REG_STAT;
            md_data_s = md_is_div ? 32'd5 : 32'd4;
        end else begin
            md_dest_s = md_rd;
            md_data_s = md_result;
        end
    end

    assign md_wr_s  = md_ready && (md_dest_s != REG_ZERO);
    assign starve_s = buf_valid_r && pipe_wr_s && (wait_cnt_r == CNT_MAX);
    assign drain_s  = buf_valid_r && (!pipe_wr_s || (wait_cnt_r == CNT_MAX));

    // Write-port arbitration: starvation drain, pipeline, buffered result, direct bypass.
    always_comb begin
        we_s    = 1'b0;
        wreg_s  = REG_ZERO;
        wdata_s = 32'd0;
        stall_s = 1'b0;
        if (!ctrl_reset) begin
            we_s    = 1'b0;
        end else if (drain_s) begin
            stall_s = starve_s;
            we_s    = 1'b1;
            wreg_s  = buf_dest_r;
            wdata_s = buf_data_r;
        end else if (pipe_wr_s) begin
            we_s    = 1'b1;
            wreg_s  = pipe_dest_s;
            wdata_s = pipe_data_s;
        end else if (md_wr_s) begin
            we_s    = 1'b1;
            wreg_s  = md_dest_s;
            wdata_s = md_data_s;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Multdiv buffer, starvation counter and sticky overrun flag.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            buf_valid_r <= 1'b0;
            buf_dest_r  <= REG_ZERO;
            buf_data_r  <= 32'd0;
            wait_cnt_r  <= 2'd0;
            overrun_r   <= 1'b0;
        end else if (drain_s) begin
            // The port is busy with the drain, so a result arriving now must be parked.
            wait_cnt_r <= 2'd0;
            if (md_wr_s) begin
                buf_valid_r <= 1'b1;
                buf_dest_r  <= md_dest_s;
                buf_data_r  <= md_data_s;
            end else begin
                buf_valid_r <= 1'b0;
            end
        end else if (buf_valid_r) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
            if (md_ready) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (md_wr_s && pipe_wr_s) begin
            buf_valid_r <= 1'b1;
            buf_dest_r  <= md_dest_s;
            buf_data_r  <= md_data_s;
            wait_cnt_r  <= 2'd0;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    assign ctrl_writeEnable = we_s;
    assign ctrl_writeReg    = we_s ? wreg_s : REG_ZERO;
    assign data_writeReg    = we_s ? wdata_s : 32'd0;
    assign wb_stall         = stall_s;
    assign md_pending       = buf_valid_r && ctrl_reset;
    assign md_overrun       = overrun_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: each step drives inputs, queues the hand-derived
// expected port state, and compares it mid-cycle before the committing edge.
module tb_wb_stage;

    logic        clock;
    logic        ctrl_reset;
    logic [31:0] in_O, in_D, in_ir;
    logic        md_ready;
    logic [31:0] md_result;
    logic [4:0]  md_rd;
    logic        md_exception, md_is_div;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        wb_stall, md_pending, md_overrun;

    typedef struct packed {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        stall;
        logic        pending;
        logic        overrun;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    wb_stage dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .in_O(in_O), .in_D(in_D), .in_ir(in_ir),
        .md_ready(md_ready), .md_result(md_result), .md_rd(md_rd),
        .md_exception(md_exception), .md_is_div(md_is_div),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wb_stall(wb_stall),
        .md_pending(md_pending), .md_overrun(md_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] aluop);
        return {op, rd, 15'd0, aluop, 2'b00};
    endfunction

    task automatic set_pipe(input logic [4:0] op, input logic [4:0] rd,
                            input logic [4:0] aluop, input logic [31:0] o, input logic [31:0] d);
        in_ir = mk_ir(op, rd, aluop);
        in_O  = o;
        in_D  = d;
    endtask

    task automatic set_md(input logic rdy, input logic [4:0] rd, input logic [31:0] res,
                          input logic exc, input logic dv);
        md_ready     = rdy;
        md_rd        = rd;
        md_result    = res;
        md_exception = exc;
        md_is_div    = dv;
    endtask

    task automatic step(input string tag, input logic we, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic stall, input logic pend,
                        input logic ovr);
        exp_t e, got, obs;
        e = '{we: we, wreg: wreg, wdata: wdata, stall: stall, pending: pend, overrun: ovr};
        sb.push_back(e);
        @(negedge clock);
        got = sb.pop_front();
        obs = '{we: ctrl_writeEnable, wreg: ctrl_writeReg, wdata: data_writeReg,
                stall: wb_stall, pending: md_pending, overrun: md_overrun};
        vectors++;
        assert (obs === got) else begin
            miscompares++;
            $error("FAIL %s: observed we=%b reg=%0d data=%h stall=%b pend=%b ovr=%b expected we=%b reg=%0d data=%h stall=%b pend=%b ovr=%b",
                   tag, obs.we, obs.wreg, obs.wdata, obs.stall, obs.pending, obs.overrun,
                   got.we, got.wreg, got.wdata, got.stall, got.pending, got.overrun);
        end
        @(posedge clock);
        #1;
    endtask

    localparam logic [4:0] OP_R = 5'b00000, OP_ADDI = 5'b00101, OP_LW = 5'b01000;
    localparam logic [4:0] OP_JAL = 5'b00011, OP_SETX = 5'b10101, OP_SW = 5'b00111;
    localparam logic [4:0] OP_BNE = 5'b00010;

    initial begin
        ctrl_reset = 1'b0;
        set_pipe(OP_SW, 5'd0, 5'd0, 32'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;

        // Reset held: outputs forced low even with a writing instruction and md result.
        set_pipe(OP_LW, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF);
        set_md(1'b1, 5'd7, 32'h55, 1'b0, 1'b0);
        step("reset_hold", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        ctrl_reset = 1'b1;
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        if (in_ir !== 32'h41400000) $display("note: lw encoding %h", in_ir);
        step("lw_r5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_LW, 5'd0, 5'd0, 32'd0, 32'hDEADBEEF);
        step("lw_r0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_JAL, 5'd0, 5'd0, 32'h10, 32'd0);
        step("jal", 1'b1, 5'd31, 32'h10, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_SETX, 5'd0, 5'd0, 32'h123, 32'd0);
        step("setx", 1'b1, 5'd30, 32'h123, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_SW, 5'd4, 5'd0, 32'h99, 32'h98);
        step("sw", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_BNE, 5'd4, 5'd0, 32'h99, 32'h98);
        step("bne", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_R, 5'd4, 5'b00000, 32'h77, 32'd0);
        step("rtype_add", 1'b1, 5'd4, 32'h77, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_R, 5'd4, 5'b00110, 32'h77, 32'd0);
        step("rtype_mul", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_R, 5'd4, 5'b00111, 32'h77, 32'd0);
        step("rtype_div", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Direct bypass on an idle cycle.
        set_pipe(OP_SW, 5'd0, 5'd0, 32'd0, 32'd0);
        set_md(1'b1, 5'd7, 32'h55, 1'b0, 1'b0);
        step("md_bypass", 1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 1'b0);
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step("idle_after_bypass", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Collision, then four pipeline writes; the fourth pending cycle stalls and drains.
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h33, 32'd0);
        set_md(1'b1, 5'd9, 32'hAA, 1'b0, 1'b0);
        step("collide", 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b0);
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h34 + 32'(i), 32'd0);
            step("pend_pipe", 1'b1, 5'd3, 32'h34 + 32'(i), 1'b0, 1'b1, 1'b0);
        end
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h37, 32'd0);
        step("starve_drain", 1'b1, 5'd9, 32'hAA, 1'b1, 1'b1, 1'b0);
        step("held_instr", 1'b1, 5'd3, 32'h37, 1'b0, 1'b0, 1'b0);

        // Capture then drain into a free port.
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h40, 32'd0);
        set_md(1'b1, 5'd12, 32'hC0, 1'b0, 1'b0);
        step("capture", 1'b1, 5'd3, 32'h40, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_SW, 5'd0, 5'd0, 32'd0, 32'd0);
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step("drain_free", 1'b1, 5'd12, 32'hC0, 1'b0, 1'b1, 1'b0);
        step("empty_again", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Exceptions report through r30; a result for r0 is discarded.
        set_md(1'b1, 5'd8, 32'h1234, 1'b1, 1'b1);
        step("div_exc", 1'b1, 5'd30, 32'd5, 1'b0, 1'b0, 1'b0);
        set_md(1'b1, 5'd8, 32'h1234, 1'b1, 1'b0);
        step("mul_exc", 1'b1, 5'd30, 32'd4, 1'b0, 1'b0, 1'b0);
        set_md(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        step("md_r0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Overrun: second result while the buffer is held by pipeline traffic.
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h50, 32'd0);
        set_md(1'b1, 5'd9, 32'hAA, 1'b0, 1'b0);
        step("ovr_capture", 1'b1, 5'd3, 32'h50, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h51, 32'd0);
        set_md(1'b1, 5'd10, 32'hBB, 1'b0, 1'b0);
        step("ovr_second", 1'b1, 5'd3, 32'h51, 1'b0, 1'b1, 1'b0);
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h52, 32'd0);
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step("ovr_sticky", 1'b1, 5'd3, 32'h52, 1'b0, 1'b1, 1'b1);

        // Reset while pending discards the buffered result and clears the flag.
        ctrl_reset = 1'b0;
        set_pipe(OP_SW, 5'd0, 5'd0, 32'd0, 32'd0);
        step("rst_pending", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        ctrl_reset = 1'b1;
        step("rst_release", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // A result arriving in a drain cycle is parked, not dropped.
        set_pipe(OP_ADDI, 5'd3, 5'd0, 32'h60, 32'd0);
        set_md(1'b1, 5'd11, 32'h11, 1'b0, 1'b0);
        step("cap_11", 1'b1, 5'd3, 32'h60, 1'b0, 1'b0, 1'b0);
        set_pipe(OP_SW, 5'd0, 5'd0, 32'd0, 32'd0);
        set_md(1'b1, 5'd13, 32'h13, 1'b0, 1'b0);
        step("drain_and_cap", 1'b1, 5'd11, 32'h11, 1'b0, 1'b1, 1'b0);
        set_md(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step("drain_13", 1'b1, 5'd13, 32'h13, 1'b0, 1'b1, 1'b0);
        step("final_idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL expose: clock  in  1  single pipeline clock, all state updates on rising edge.
REQ-002 SHALL expose: ctrl_reset  in  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-003 SHALL expose: in_O, in_D, in_ir  in  32 each  ALU/PC result, load data and instruction from the memory/writeback latch.
REQ-004 SHALL expose: md_ready  in  1  single-cycle pulse, multdiv result valid.
REQ-005 SHALL expose: md_result  in  32; md_rd  in  5 (destination captured at issue); md_exception  in  1; md_is_div  in  1.
REQ-006 SHALL expose: ctrl_writeEnable  out  1; ctrl_writeReg  out  5; data_writeReg  out  32  register-file write port.
REQ-007 SHALL expose: wb_stall  out  1  when high, the memory/writeback latch and all upstream latches hold.
REQ-008 SHALL expose: md_pending  out  1  buffer valid, blocks new mul/div issue.
REQ-009 SHALL expose: md_overrun  out  1  sticky protocol-error flag.

Function
REQ-010 SHALL decode in_ir: opcode = [31:27], rd = [26:22], aluop = [6:2].
REQ-011 Pipeline writes SHALL be: R-type 00000 with aluop not 00110/00111 -> rd <= in_O; addi 00101 -> rd <= in_O; lw 01000 -> rd <= in_D; jal 00011 -> r31 <= in_O; setx 10101 -> r30 <= in_O; all other opcodes, and R-type mul/div, -> no pipeline write.
REQ-012 A write whose destination is r0 SHALL be suppressed; this applies to both pipeline and multdiv writes.
REQ-013 Multdiv write data SHALL be md_result to md_rd, except that md_exception=1 SHALL write r30 <= 4 (mul) or 5 (div, md_is_div=1).
REQ-014 SHALL hold a 1-entry multdiv buffer (valid, dest, data) and a 2-bit wait counter.
REQ-015 Write-port outputs SHALL be combinational from inputs and buffer state; the register file commits on the next rising edge.
REQ-016 Port priority SHALL be: starvation drain > pipeline write > buffered result > new md result (direct bypass).
REQ-017 Buffer empty, md_ready=1, no pipeline write: SHALL write the md result in the same cycle, with no buffer capture.
REQ-018 Buffer empty, md_ready=1, pipeline write present: SHALL perform the pipeline write, capture the md result into the buffer (valid next cycle), and clear the counter to 0.
REQ-019 Buffer valid, no pipeline write: SHALL drain the buffer to the port and clear valid at the edge.
REQ-020 Buffer valid, pipeline write, counter<3: SHALL perform the pipeline write and increment the counter.
REQ-021 Buffer valid, pipeline write, counter==3: SHALL assert wb_stall, drain the buffer, suppress the pipeline write, and clear the counter; the held instruction writes in the following cycle.
REQ-022 wb_stall SHALL be high only in the REQ-021 condition.
REQ-023 md_pending SHALL equal buffer valid.
REQ-024 md_ready=1 while the buffer is valid and not draining that cycle SHALL set md_overrun, and the new result SHALL be dropped; md_ready in the drain cycle SHALL be treated per REQ-017/018 after the drain (i.e. captured, since the port is busy).
REQ-025 md_overrun SHALL remain high until reset.
REQ-026 ctrl_writeEnable=0 SHALL force ctrl_writeReg=0 and data_writeReg=0.

Reset
REQ-027 ctrl_reset low at a rising edge SHALL clear buffer valid, dest, data, counter and md_overrun.
REQ-028 While ctrl_reset is low, ctrl_writeEnable, wb_stall and md_pending SHALL be 0 regardless of inputs.
REQ-029 Reset asserted with a buffered result SHALL discard that result, with no write.
REQ-030 Release SHALL be effective at the first edge with ctrl_reset high.

Verification
REQ-031 lw r5 (ir=0x41400000), in_D=0xDEADBEEF -> writeEnable=1, writeReg=5, data=0xDEADBEEF; the same with rd=0 -> writeEnable=0.
REQ-032 jal with in_O=0x00000010 -> write r31=0x10; setx with in_O=0x00000123 -> write r30=0x123; sw/bne -> no write.
REQ-033 md_ready with md_rd=7, result=0x55 on an idle cycle -> same-cycle write r7=0x55, md_pending stays 0.
REQ-034 md_ready (rd=9, 0xAA) together with addi r3, then 4 further pipeline writes -> md_pending 1; on the 4th pending cycle wb_stall=1 and r9=0xAA is written; the held instruction writes the next cycle.
REQ-035 div exception (md_exception=1, md_is_div=1) -> write r30=5; second md_ready while pending -> md_overrun=1, sticky until reset.
REQ-036 Reset pulse while pending -> md_pending=0, no r9 write, md_overrun=0.
